serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor_if.sv | 27 ++
 rtl/serial_subtractor.sv | 137 +++++++++++++
 tb/tb_serial_subtractor.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// Start/Done handshake and operand/result bundle for serial_subtractor.
//   master : drives Start, A, B, Bin; observes Busy, Done, D, Bout, V
//   slave  : the subtractor side of the same signals
// N is the operand/result width in bits.
interface serial_subtractor_if #(
    parameter int N = 8
);
    logic         Start;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         Bin;
    logic         Busy;
    logic         Done;
    logic [N-1:0] D;
    logic         Bout;
    logic         V;

    modport master (
        output Start, A, B, Bin,
        input  Busy, Done, D, Bout, V
    );

    modport slave (
        input  Start, A, B, Bin,
        output Busy, Done, D, Bout, V
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: D = A - B - Bin, one bit per
// clock, LSB first, with a single registered borrow.
// Ports:
//   CLK  - clock, rising edge
//   RST  - synchronous active-high reset
//   bus  - serial_subtractor_if.slave (Start/A/B/Bin in, Busy/Done/D/Bout/V out)
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for Start; D/Bout/V hold the last result
// RUN    | one difference bit resolved per cycle, N cycles
// DONE   | Done pulse; a Start here launches the next operation
module serial_subtractor #(
    parameter int N = 8
) (
    input  logic                CLK,
    input  logic                RST,
    serial_subtractor_if.slave  bus
);
    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   a_sh_q, a_sh_d;
    logic [N-1:0]   b_sh_q, b_sh_d;
    logic [N-1:0]   d_q, d_d;
    logic           bw_q, bw_d;
    logic           bout_q, bout_d;
    logic           v_q, v_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic           bit_a, bit_b, diff, bw_next;
    logic           last_bit, accept;

    // Start is only honoured when not busy; DONE accepts it for back-to-back use.
    assign accept   = bus.Start && (state_q != S_RUN);
    assign last_bit = (cnt_q == CW'(N - 1));

    // Full-subtractor cell on the current LSBs.
    assign bit_a   = a_sh_q[0];
    assign bit_b   = b_sh_q[0];
    assign diff    = bit_a ^ bit_b ^ bw_q;
    assign bw_next = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & bw_q);

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = S_RUN;
            S_RUN:  if (last_bit) state_d = S_DONE;
            S_DONE: state_d = accept ? S_RUN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        bus.Busy = 1'b0;
        bus.Done = 1'b0;
        case (state_q)
            S_RUN:   bus.Busy = 1'b1;
            S_DONE:  bus.Done = 1'b1;
            default: ;
        endcase
    end

    assign bus.D    = d_q;
    assign bus.Bout = bout_q;
    assign bus.V    = v_q;

    // Datapath next-value logic
    always_comb begin
        a_sh_d = a_sh_q;
        b_sh_d = b_sh_q;
        d_d    = d_q;
        bw_d   = bw_q;
        bout_d = bout_q;
        v_d    = v_q;
        cnt_d  = cnt_q;
        if (accept) begin
            a_sh_d = bus.A;
            b_sh_d = bus.B;
            bw_d   = bus.Bin;
            d_d    = '0;
            bout_d = 1'b0;
            v_d    = 1'b0;
            cnt_d  = '0;
        end else if (state_q == S_RUN) begin
            a_sh_d = {1'b0, a_sh_q[N-1:1]};
            b_sh_d = {1'b0, b_sh_q[N-1:1]};
            d_d    = {diff, d_q[N-1:1]};
            bw_d   = bw_next;
            cnt_d  = cnt_q + CW'(1);
            if (last_bit) begin
                // On the last bit the shift LSBs are the original sign bits,
                // and diff becomes the result sign bit.
                bout_d = bw_next;
                v_d    = (bit_a ^ bit_b) & (diff ^ bit_a);
            end
        end
    end

    // Datapath registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            a_sh_q <= '0;
            b_sh_q <= '0;
            d_q    <= '0;
            bw_q   <= 1'b0;
            bout_q <= 1'b0;
            v_q    <= 1'b0;
            cnt_q  <= '0;
        end else begin
            a_sh_q <= a_sh_d;
            b_sh_q <= b_sh_d;
            d_q    <= d_d;
            bw_q   <= bw_d;
            bout_q <= bout_d;
            v_q    <= v_d;
            cnt_q  <= cnt_d;
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: N=8 directed vectors and
// handshake corner cases, plus an N=4 exhaustive sweep against a model.
module tb_serial_subtractor;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    serial_subtractor_if #(.N(8)) if8 ();
    serial_subtractor_if #(.N(4)) if4 ();

    serial_subtractor #(.N(8)) dut8 (.CLK(clk), .RST(rst), .bus(if8));
    serial_subtractor #(.N(4)) dut4 (.CLK(clk), .RST(rst), .bus(if4));

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] d;
        logic       bout;
        logic       v;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                        input logic [7:0] ed, input logic eb, input logic ev);
        int cyc;
        int busy;
        @(negedge clk);
        if8.Start = 1'b1; if8.A = a; if8.B = b; if8.Bin = bin;
        @(posedge clk);
        @(negedge clk);
        if8.Start = 1'b0; if8.A = ~a; if8.B = ~b; if8.Bin = ~bin;
        cyc = 1; busy = 0;
        while (!if8.Done && cyc <= 20) begin
            busy += int'(if8.Busy);
            @(negedge clk);
            cyc++;
        end
        chk("latency8", 16'(cyc - 1), 16'd8);
        chk("busy_cycles8", 16'(busy), 16'd8);
        chk("d8", {8'h00, if8.D}, {8'h00, ed});
        chk("bout8", {15'h0, if8.Bout}, {15'h0, eb});
        chk("v8", {15'h0, if8.V}, {15'h0, ev});
        @(negedge clk);
        chk("done_single8", {15'h0, if8.Done}, 16'h0);
    endtask

    task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic bin);
        int cyc;
        int r, sa, sb;
        logic [3:0] ed;
        logic eb, ev;
        r  = int'(a) - int'(b) - int'(bin);
        ed = r[3:0];
        eb = (int'(a) < int'(b) + int'(bin));
        sa = (a >= 4'd8) ? int'(a) - 16 : int'(a);
        sb = (b >= 4'd8) ? int'(b) - 16 : int'(b);
        r  = sa - sb - int'(bin);
        ev = (r < -8) || (r > 7);
        @(negedge clk);
        if4.Start = 1'b1; if4.A = a; if4.B = b; if4.Bin = bin;
        @(posedge clk);
        @(negedge clk);
        if4.Start = 1'b0;
        cyc = 1;
        while (!if4.Done && cyc <= 12) begin
            @(negedge clk);
            cyc++;
        end
        chk("latency4", 16'(cyc - 1), 16'd4);
        chk("result4", {10'h0, if4.D, if4.Bout, if4.V}, {10'h0, ed, eb, ev});
    endtask

    initial begin
        int cyc, dones, gap;
        logic [7:0] dcap;

        vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
        vecs[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0};
        vecs[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        vecs[4] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
        vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[6] = '{8'h00, 8'h80, 1'b0, 8'h80, 1'b1, 1'b1};
        vecs[7] = '{8'h80, 8'h00, 1'b1, 8'h7F, 1'b0, 1'b1};

        if8.Start = 1'b0; if8.A = '0; if8.B = '0; if8.Bin = 1'b0;
        if4.Start = 1'b0; if4.A = '0; if4.B = '0; if4.Bin = 1'b0;
        // Start held high during reset must not launch anything.
        if8.Start = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        if8.Start = 1'b0;
        chk("rst_busy", {15'h0, if8.Busy}, 16'h0);
        chk("rst_done", {15'h0, if8.Done}, 16'h0);
        chk("rst_outs", {6'h0, if8.D, if8.Bout, if8.V}, 16'h0);

        for (int i = 0; i < 8; i++)
            run8(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].d, vecs[i].bout, vecs[i].v);

        // Start while busy is ignored.
        @(negedge clk);
        if8.Start = 1'b1; if8.A = 8'h05; if8.B = 8'h03; if8.Bin = 1'b0;
        @(posedge clk);
        @(negedge clk);
        if8.Start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        if8.Start = 1'b1; if8.A = 8'h10; if8.B = 8'h01;
        @(negedge clk);
        if8.Start = 1'b0;
        dones = 0; dcap = 8'h00;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (if8.Done) begin
                dones++;
                dcap = if8.D;
            end
        end
        chk("ignore_dones", 16'(dones), 16'd1);
        chk("ignore_d", {8'h0, dcap}, 16'h0002);

        // Reset in the middle of an operation.
        @(negedge clk);
        if8.Start = 1'b1; if8.A = 8'h05; if8.B = 8'h03; if8.Bin = 1'b0;
        @(posedge clk);
        @(negedge clk);
        if8.Start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", {15'h0, if8.Busy}, 16'h0);
        chk("midrst_done", {15'h0, if8.Done}, 16'h0);
        chk("midrst_outs", {6'h0, if8.D, if8.Bout, if8.V}, 16'h0);
        dones = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            dones += int'(if8.Done);
        end
        chk("midrst_nodone", 16'(dones), 16'd0);
        run8(8'h09, 8'h04, 1'b0, 8'h05, 1'b0, 1'b0);

        // Back-to-back with Start held in the DONE cycle.
        @(negedge clk);
        if8.Start = 1'b1; if8.A = 8'h05; if8.B = 8'h03; if8.Bin = 1'b0;
        @(posedge clk);
        @(negedge clk);
        if8.Start = 1'b0;
        cyc = 1;
        while (!if8.Done && cyc <= 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("b2b_first_done", {15'h0, if8.Done}, 16'h1);
        chk("b2b_first_d", {8'h0, if8.D}, 16'h0002);
        if8.Start = 1'b1; if8.A = 8'h03; if8.B = 8'h05;
        @(posedge clk);
        @(negedge clk);
        if8.Start = 1'b0;
        gap = 1;
        while (!if8.Done && gap <= 20) begin
            @(negedge clk);
            gap++;
        end
        chk("b2b_gap", 16'(gap), 16'd9);
        chk("b2b_second", {7'h0, if8.D, if8.Bout}, {7'h0, 8'hFE, 1'b1});

        // N=4 back-to-back.
        @(negedge clk);
        if4.Start = 1'b1; if4.A = 4'h5; if4.B = 4'h3; if4.Bin = 1'b0;
        @(posedge clk);
        @(negedge clk);
        if4.Start = 1'b0;
        cyc = 1;
        while (!if4.Done && cyc <= 12) begin
            @(negedge clk);
            cyc++;
        end
        chk("b2b4_first", {12'h0, if4.D}, 16'h0002);
        if4.Start = 1'b1; if4.A = 4'h3; if4.B = 4'h5;
        @(posedge clk);
        @(negedge clk);
        if4.Start = 1'b0;
        gap = 1;
        while (!if4.Done && gap <= 12) begin
            @(negedge clk);
            gap++;
        end
        chk("b2b4_gap", 16'(gap), 16'd5);
        chk("b2b4_second", {11'h0, if4.D, if4.Bout}, {11'h0, 4'hE, 1'b1});

        // N=4 exhaustive sweep.
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int c = 0; c < 2; c++)
                    run4(4'(a), 4'(b), 1'(c));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
